decode_queue: RTL and testbench

//  Buffered, registered successor of the combinational decode stage. Holds DEPTH fetched

---
 rtl/decode_queue.sv | 243 ++++++++++++++++++++++++
 tb/tb_decode_queue.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_queue.sv
// Decode queue: DEPTH-entry instruction FIFO, decoding at the head and a registered issue bundle
// toward RoB + RS/LSB. Define DECODE_CDB_BYPASS_EN to forward a same-cycle CDB result into operands.
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 4
`endif

module decode_queue #(
  parameter int DEPTH = 4,
  parameter int ROB_W = `ROB_SIZE_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic             instr_ready,
  input  logic [31:0]      instr_in,
  input  logic [31:0]      instr_addr_in,
  output logic             queue_full,
  input  logic             rob_full,
  input  logic             rs_full,
  input  logic             lsb_full,
  output logic [4:0]       reg_id1,
  output logic [4:0]       reg_id2,
  input  logic [31:0]      reg_value1_in,
  input  logic [31:0]      reg_value2_in,
  input  logic             has_dep1_in,
  input  logic             has_dep2_in,
  input  logic [ROB_W-1:0] v_rob_id1_in,
  input  logic [ROB_W-1:0] v_rob_id2_in,
  input  logic [ROB_W-1:0] rd_rob_id_in,
  input  logic             cdb_valid,
  input  logic [ROB_W-1:0] cdb_rob_id,
  input  logic [31:0]      cdb_value,
  output logic             issue_valid,
  output logic             issue_to_rs,
  output logic             issue_to_lsb,
  output logic [31:0]      instr_out,
  output logic [31:0]      instr_addr_out,
  output logic [31:0]      imm_out,
  output logic [2:0]       op_out,
  output logic [6:0]       type_out,
  output logic [4:0]       rd_out,
  output logic [31:0]      val1,
  output logic [31:0]      val2,
  output logic             dep1,
  output logic             dep2,
  output logic [ROB_W-1:0] q1,
  output logic [ROB_W-1:0] q2,
  output logic [ROB_W-1:0] rd_rob_id_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_B     = 7'b1100011;
  localparam logic [6:0] OPC_LD    = 7'b0000011;
  localparam logic [6:0] OPC_S     = 7'b0100011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_R     = 7'b0110011;

  typedef struct packed {
    logic             to_rs;
    logic             to_lsb;
    logic [31:0]      instr;
    logic [31:0]      addr;
    logic [31:0]      imm;
    logic [2:0]       op;
    logic [6:0]       typ;
    logic [4:0]       rd;
    logic [31:0]      val1;
    logic [31:0]      val2;
    logic             dep1;
    logic             dep2;
    logic [ROB_W-1:0] q1;
    logic [ROB_W-1:0] q2;
    logic [ROB_W-1:0] rd_tag;
  } bundle_t;

  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   addr_mem  [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          issue_valid_q, issue_valid_d;
  bundle_t       bundle_q, bundle_d, issue_bundle;

  logic [31:0] head_instr, head_addr, head_imm;
  logic [6:0]  opcode;
  logic        is_lsb, has_rs1, has_rs2, has_rd, fire, push;

  assign head_instr = instr_mem[head_q];
  assign head_addr  = addr_mem[head_q];
  assign opcode     = head_instr[6:0];
  assign reg_id1    = head_instr[19:15];
  assign reg_id2    = head_instr[24:20];

  assign is_lsb  = (opcode == OPC_LD) || (opcode == OPC_S);
  assign has_rs1 = !((opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL));
  assign has_rs2 = (opcode == OPC_R) || (opcode == OPC_S) || (opcode == OPC_B);
  assign has_rd  = !((opcode == OPC_B) || (opcode == OPC_S)) && (head_instr[11:7] != 5'd0);

  // A full queue still accepts a word when the head leaves in the same cycle.
  assign fire = rdy && !flush && (count_q != '0) && !rob_full && !(is_lsb ? lsb_full : rs_full);
  assign push = rdy && !flush && instr_ready && ((count_q != CW'(DEPTH)) || fire);
  assign queue_full = (count_q == CW'(DEPTH));

  always_comb begin
    head_imm = '0;
    case (opcode)
      OPC_LUI, OPC_AUIPC:  head_imm = {head_instr[31:12], 12'h000};
      OPC_JAL:             head_imm = {{12{head_instr[31]}}, head_instr[19:12], head_instr[20],
                                       head_instr[30:21], 1'b0};
      OPC_I, OPC_JALR, OPC_LD: head_imm = {{20{head_instr[31]}}, head_instr[31:20]};
      OPC_B:               head_imm = {{20{head_instr[31]}}, head_instr[7], head_instr[30:25],
                                       head_instr[11:8], 1'b0};
      OPC_S:               head_imm = {{20{head_instr[31]}}, head_instr[31:25], head_instr[11:7]};
      default:             head_imm = '0;
    endcase
  end

  // Operand resolution: index 0 is rs1, index 1 is rs2.
  logic [31:0]      opnd_val_in [2];
  logic             opnd_dep_in [2];
  logic [ROB_W-1:0] opnd_q_in   [2];
  logic             opnd_used   [2];
  logic [31:0]      opnd_val    [2];
  logic             opnd_dep    [2];
  logic [ROB_W-1:0] opnd_q      [2];

  assign opnd_val_in[0] = reg_value1_in;
  assign opnd_val_in[1] = reg_value2_in;
  assign opnd_dep_in[0] = has_dep1_in;
  assign opnd_dep_in[1] = has_dep2_in;
  assign opnd_q_in[0]   = v_rob_id1_in;
  assign opnd_q_in[1]   = v_rob_id2_in;
  assign opnd_used[0]   = has_rs1;
  assign opnd_used[1]   = has_rs2;

`ifndef DECODE_CDB_BYPASS_EN
  logic unused_cdb;
  assign unused_cdb = ^{cdb_valid, cdb_rob_id, cdb_value};
`endif

  for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
    logic hit;
`ifdef DECODE_CDB_BYPASS_EN
    assign hit = cdb_valid && opnd_dep_in[gi] && (opnd_q_in[gi] == cdb_rob_id);
`else
    assign hit = 1'b0;
`endif
    assign opnd_val[gi] = !opnd_used[gi] ? '0 : (hit ? cdb_value : opnd_val_in[gi]);
    assign opnd_dep[gi] = opnd_used[gi] && opnd_dep_in[gi] && !hit;
    assign opnd_q[gi]   = (!opnd_used[gi] || hit) ? '0 : opnd_q_in[gi];
  end

  always_comb begin
    issue_bundle        = '0;
    issue_bundle.to_rs  = !is_lsb;
    issue_bundle.to_lsb = is_lsb;
    issue_bundle.instr  = head_instr;
    issue_bundle.addr   = head_addr;
    issue_bundle.imm    = head_imm;
    issue_bundle.op     = head_instr[14:12];
    issue_bundle.typ    = opcode;
    issue_bundle.rd     = has_rd ? head_instr[11:7] : 5'd0;
    issue_bundle.val1   = opnd_val[0];
    issue_bundle.val2   = opnd_val[1];
    issue_bundle.dep1   = opnd_dep[0];
    issue_bundle.dep2   = opnd_dep[1];
    issue_bundle.q1     = opnd_q[0];
    issue_bundle.q2     = opnd_q[1];
    issue_bundle.rd_tag = has_rd ? rd_rob_id_in : '0;
  end

  always_comb begin
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    bundle_d      = bundle_q;
    issue_valid_d = 1'b0;
    if (rdy && flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (fire) begin
        bundle_d      = issue_bundle;
        issue_valid_d = 1'b1;
        head_d        = head_q + 1'b1;
      end
      if (push) tail_d = tail_q + 1'b1;
      case ({push, fire})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      issue_valid_q <= 1'b0;
      bundle_q      <= '0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      issue_valid_q <= issue_valid_d;
      bundle_q      <= bundle_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[tail_q] <= instr_in;
      addr_mem[tail_q]  <= instr_addr_in;
    end
  end

  assign issue_valid    = issue_valid_q;
  assign issue_to_rs    = bundle_q.to_rs;
  assign issue_to_lsb   = bundle_q.to_lsb;
  assign instr_out      = bundle_q.instr;
  assign instr_addr_out = bundle_q.addr;
  assign imm_out        = bundle_q.imm;
  assign op_out         = bundle_q.op;
  assign type_out       = bundle_q.typ;
  assign rd_out         = bundle_q.rd;
  assign val1           = bundle_q.val1;
  assign val2           = bundle_q.val2;
  assign dep1           = bundle_q.dep1;
  assign dep2           = bundle_q.dep2;
  assign q1             = bundle_q.q1;
  assign q2             = bundle_q.q2;
  assign rd_rob_id_out  = bundle_q.rd_tag;

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_decode_queue;
  localparam int DEPTH = 4;
  localparam int RW    = 4;

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_B     = 7'b1100011;
  localparam logic [6:0] OPC_LD    = 7'b0000011;
  localparam logic [6:0] OPC_S     = 7'b0100011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE = 7'b0001111;
  localparam logic [6:0] OPS [10] = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_B,
                                      OPC_LD, OPC_S, OPC_I, OPC_R, OPC_FENCE};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, rdy, flush, instr_ready;
  logic [31:0]   instr_in, instr_addr_in;
  logic          queue_full, rob_full, rs_full, lsb_full;
  logic [4:0]    reg_id1, reg_id2;
  logic [31:0]   reg_value1_in, reg_value2_in;
  logic          has_dep1_in, has_dep2_in;
  logic [RW-1:0] v_rob_id1_in, v_rob_id2_in, rd_rob_id_in;
  logic          cdb_valid;
  logic [RW-1:0] cdb_rob_id;
  logic [31:0]   cdb_value;
  logic          issue_valid, issue_to_rs, issue_to_lsb;
  logic [31:0]   instr_out, instr_addr_out, imm_out;
  logic [2:0]    op_out;
  logic [6:0]    type_out;
  logic [4:0]    rd_out;
  logic [31:0]   val1, val2;
  logic          dep1, dep2;
  logic [RW-1:0] q1, q2, rd_rob_id_out;

  // Register-file stand-in: operand values are a function of the register id and per-cycle salts.
  logic [31:0] reg_salt, dep_salt;
  logic [1:0]  q_salt, qa1, qa2;
  assign reg_value1_in = reg_salt + 32'(reg_id1);
  assign reg_value2_in = ~reg_salt + 32'(reg_id2);
  assign has_dep1_in   = dep_salt[reg_id1];
  assign has_dep2_in   = dep_salt[reg_id2];
  assign qa1           = reg_id1[1:0] + q_salt;
  assign qa2           = reg_id2[1:0] + q_salt;
  assign v_rob_id1_in  = {2'b00, qa1};
  assign v_rob_id2_in  = {2'b00, qa2};

  decode_queue #(.DEPTH(DEPTH), .ROB_W(RW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .instr_ready(instr_ready),
    .instr_in(instr_in), .instr_addr_in(instr_addr_in), .queue_full(queue_full),
    .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
    .reg_id1(reg_id1), .reg_id2(reg_id2),
    .reg_value1_in(reg_value1_in), .reg_value2_in(reg_value2_in),
    .has_dep1_in(has_dep1_in), .has_dep2_in(has_dep2_in),
    .v_rob_id1_in(v_rob_id1_in), .v_rob_id2_in(v_rob_id2_in), .rd_rob_id_in(rd_rob_id_in),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
    .issue_valid(issue_valid), .issue_to_rs(issue_to_rs), .issue_to_lsb(issue_to_lsb),
    .instr_out(instr_out), .instr_addr_out(instr_addr_out), .imm_out(imm_out),
    .op_out(op_out), .type_out(type_out), .rd_out(rd_out),
    .val1(val1), .val2(val2), .dep1(dep1), .dep2(dep2), .q1(q1), .q2(q2),
    .rd_rob_id_out(rd_rob_id_out)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  typedef struct packed {
    logic          to_rs;
    logic          to_lsb;
    logic [31:0]   instr;
    logic [31:0]   addr;
    logic [31:0]   imm;
    logic [2:0]    op;
    logic [6:0]    typ;
    logic [4:0]    rd;
    logic [31:0]   v1;
    logic [31:0]   v2;
    logic          d1;
    logic          d2;
    logic [RW-1:0] q1;
    logic [RW-1:0] q2;
    logic [RW-1:0] tag;
  } exp_t;

  function automatic void operand(input bit en, input logic [4:0] id, input logic [31:0] base,
                                  output logic [31:0] v, output logic d, output logic [RW-1:0] q);
    logic [1:0] t;
    v = '0; d = 1'b0; q = '0;
    if (en) begin
      t = id[1:0] + q_salt;
      v = base + 32'(id);
      d = dep_salt[id];
      q = {2'b00, t};
`ifdef DECODE_CDB_BYPASS_EN
      if (d && cdb_valid && q == cdb_rob_id) begin
        v = cdb_value; d = 1'b0; q = '0;
      end
`endif
    end
  endfunction

  function automatic exp_t predict(input logic [31:0] i, input logic [31:0] pc);
    exp_t e;
    logic [6:0] opc;
    bit en1, en2, en_rd;
    opc = i[6:0];
    e = '0;
    e.instr  = i;
    e.addr   = pc;
    e.op     = i[14:12];
    e.typ    = opc;
    e.to_lsb = (opc == OPC_LD) || (opc == OPC_S);
    e.to_rs  = !e.to_lsb;
    case (opc)
      OPC_LUI, OPC_AUIPC:      e.imm = {i[31:12], 12'h000};
      OPC_JAL:                 e.imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      OPC_I, OPC_JALR, OPC_LD: e.imm = 32'($signed(i[31:20]));
      OPC_B:                   e.imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      OPC_S:                   e.imm = 32'($signed({i[31:25], i[11:7]}));
      default:                 e.imm = '0;
    endcase
    en1   = !(opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
    en2   = opc inside {OPC_R, OPC_S, OPC_B};
    en_rd = !(opc inside {OPC_B, OPC_S}) && (i[11:7] != 5'd0);
    e.rd  = en_rd ? i[11:7] : 5'd0;
    e.tag = en_rd ? rd_rob_id_in : '0;
    operand(en1, i[19:15], reg_salt, e.v1, e.d1, e.q1);
    operand(en2, i[24:20], ~reg_salt, e.v2, e.d2, e.q2);
    return e;
  endfunction

  // Reference model: a queue of {pc, instr}; the bundle is the last prediction that issued.
  logic [63:0] mq [$];
  exp_t        exp_b;
  logic        exp_valid;
  logic [63:0] m_head;
  logic        m_lsb;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      exp_valid = 1'b0;
      exp_b     = '0;
    end else begin
      exp_valid = 1'b0;
      if (rdy) begin
        if (flush) begin
          mq.delete();
        end else begin
          if (mq.size() > 0) begin
            m_head = mq[0];
            m_lsb  = (m_head[6:0] == OPC_LD) || (m_head[6:0] == OPC_S);
            if (!rob_full && !(m_lsb ? lsb_full : rs_full)) begin
              exp_b     = predict(m_head[31:0], m_head[63:32]);
              exp_valid = 1'b1;
              void'(mq.pop_front());
            end
          end
          if (instr_ready && mq.size() < DEPTH) mq.push_back({instr_addr_in, instr_in});
        end
      end
    end
  end

  logic [63:0] c_head;
  always @(posedge clk) begin
    #1;
    if (rst) begin
      chk("issue_valid", 32'(issue_valid), 32'(exp_valid));
      chk("queue_full", 32'(queue_full), 32'(mq.size() == DEPTH));
      chk("to_rs", 32'(issue_to_rs), 32'(exp_b.to_rs));
      chk("to_lsb", 32'(issue_to_lsb), 32'(exp_b.to_lsb));
      chk("instr_out", instr_out, exp_b.instr);
      chk("instr_addr_out", instr_addr_out, exp_b.addr);
      chk("imm_out", imm_out, exp_b.imm);
      chk("op_out", 32'(op_out), 32'(exp_b.op));
      chk("type_out", 32'(type_out), 32'(exp_b.typ));
      chk("rd_out", 32'(rd_out), 32'(exp_b.rd));
      chk("val1", val1, exp_b.v1);
      chk("val2", val2, exp_b.v2);
      chk("dep1", 32'(dep1), 32'(exp_b.d1));
      chk("dep2", 32'(dep2), 32'(exp_b.d2));
      chk("q1", 32'(q1), 32'(exp_b.q1));
      chk("q2", 32'(q2), 32'(exp_b.q2));
      chk("rd_rob_id_out", 32'(rd_rob_id_out), 32'(exp_b.tag));
      if (mq.size() > 0) begin
        c_head = mq[0];
        chk("reg_id1", 32'(reg_id1), 32'(c_head[19:15]));
        chk("reg_id2", 32'(reg_id2), 32'(c_head[24:20]));
      end
    end
  end

  task automatic push(input logic [31:0] w, input logic [31:0] pc);
    instr_ready   = 1'b1;
    instr_in      = w;
    instr_addr_in = pc;
    @(negedge clk);
    instr_ready   = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom();
    return {r[31:7], OPS[$urandom_range(0, 9)]};
  endfunction

  initial begin
    rst = 1'b0; rdy = 1'b1; flush = 1'b0; instr_ready = 1'b0;
    instr_in = '0; instr_addr_in = '0;
    rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0;
    reg_salt = '0; dep_salt = '0; q_salt = '0;
    rd_rob_id_in = 4'd7; cdb_valid = 1'b0; cdb_rob_id = '0; cdb_value = '0;
    repeat (2) @(negedge clk);
    chk("reset issue_valid", 32'(issue_valid), 32'd0);
    chk("reset queue_full", 32'(queue_full), 32'd0);
    chk("reset to_rs", 32'(issue_to_rs), 32'd0);
    chk("reset instr_out", instr_out, 32'd0);
    chk("reset imm_out", imm_out, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // addi x1,x0,5 issues two edges after it is offered
    push(32'h00500093, 32'h0);
    @(negedge clk);
    chk("addi valid", 32'(issue_valid), 32'd1);
    chk("addi to_rs", 32'(issue_to_rs), 32'd1);
    chk("addi imm", imm_out, 32'd5);
    chk("addi rd", 32'(rd_out), 32'd1);
    chk("addi dep1", 32'(dep1), 32'd0);
    chk("addi val2", val2, 32'd0);
    chk("addi rd_tag", 32'(rd_rob_id_out), 32'd7);

    // fill under rob_full, fifth word dropped, then drain in order
    rob_full = 1'b1;
    for (int k = 0; k < 4; k++) push(32'h00500093, 32'h100 + 32'(4 * k));
    chk("fill queue_full", 32'(queue_full), 32'd1);
    push(32'h00500093, 32'h110);
    chk("drop queue_full", 32'(queue_full), 32'd1);
    rob_full = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("drain valid", 32'(issue_valid), 32'd1);
      chk("drain pc", instr_addr_out, 32'h100 + 32'(4 * k));
    end
    @(negedge clk);
    chk("drain dropped", 32'(issue_valid), 32'd0);

    // store held by lsb_full
    lsb_full = 1'b1;
    push(32'h0020A223, 32'h200);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("sw stalled", 32'(issue_valid), 32'd0);
    end
    lsb_full = 1'b0;
    @(negedge clk);
    chk("sw valid", 32'(issue_valid), 32'd1);
    chk("sw to_lsb", 32'(issue_to_lsb), 32'd1);
    chk("sw imm", imm_out, 32'd4);
    chk("sw rd", 32'(rd_out), 32'd0);
    chk("sw rd_tag", 32'(rd_rob_id_out), 32'd0);

    // flush beats a simultaneous push
    rob_full = 1'b1;
    for (int k = 0; k < 3; k++) push(32'h00500093, 32'h300 + 32'(4 * k));
    flush = 1'b1; instr_ready = 1'b1; instr_in = 32'h00500093; instr_addr_in = 32'h3F0;
    rob_full = 1'b0;
    @(negedge clk);
    flush = 1'b0; instr_ready = 1'b0;
    chk("flush valid", 32'(issue_valid), 32'd0);
    chk("flush queue_full", 32'(queue_full), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("flush empty", 32'(issue_valid), 32'd0);
    end

    // add x3,x1,x2 with rs1 waiting on tag 3 while the CDB broadcasts tag 3
    dep_salt = 32'h2; q_salt = 2'd2;
    cdb_valid = 1'b1; cdb_rob_id = 4'd3; cdb_value = 32'hDEAD;
    push(32'h002081B3, 32'h400);
    @(negedge clk);
    chk("bypass valid", 32'(issue_valid), 32'd1);
`ifdef DECODE_CDB_BYPASS_EN
    chk("bypass dep1", 32'(dep1), 32'd0);
    chk("bypass val1", val1, 32'hDEAD);
    chk("bypass q1", 32'(q1), 32'd0);
`else
    chk("nobypass dep1", 32'(dep1), 32'd1);
    chk("nobypass q1", 32'(q1), 32'd3);
    chk("nobypass val1", val1, 32'd1);
`endif
    cdb_valid = 1'b0; dep_salt = '0; q_salt = '0;

    // full queue: push and issue in the same cycle
    rob_full = 1'b1;
    for (int k = 0; k < 4; k++) push(32'h00500093, 32'h500 + 32'(4 * k));
    rob_full = 1'b0;
    push(32'h00500093, 32'h510);
    chk("fullpi queue_full", 32'(queue_full), 32'd1);
    chk("fullpi pc0", instr_addr_out, 32'h500);
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      chk("fullpi valid", 32'(issue_valid), 32'd1);
      chk("fullpi pc", instr_addr_out, 32'h500 + 32'(4 * k));
    end

    // asynchronous reset in the middle of traffic
    instr_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      instr_in = 32'h00500093; instr_addr_in = 32'h600 + 32'(4 * k);
      @(negedge clk);
    end
    rst = 1'b0;
    #1;
    chk("midrst valid", 32'(issue_valid), 32'd0);
    chk("midrst queue_full", 32'(queue_full), 32'd0);
    chk("midrst instr_out", instr_out, 32'd0);
    chk("midrst pc", instr_addr_out, 32'd0);
    chk("midrst to_rs", 32'(issue_to_rs), 32'd0);
    @(negedge clk);
    instr_ready = 1'b0;
    rst = 1'b1;

    // randomized traffic
    for (int n = 0; n < 2500; n++) begin
      @(negedge clk);
      rdy           = ($urandom_range(0, 9) != 0);
      flush         = ($urandom_range(0, 39) == 0);
      instr_ready   = ($urandom_range(0, 9) < 7);
      instr_in      = rand_instr();
      instr_addr_in = $urandom() & 32'hFFFF_FFFC;
      rob_full      = ($urandom_range(0, 3) == 0);
      rs_full       = ($urandom_range(0, 3) == 0);
      lsb_full      = ($urandom_range(0, 3) == 0);
      reg_salt      = $urandom();
      dep_salt      = $urandom();
      q_salt        = 2'($urandom_range(0, 3));
      rd_rob_id_in  = 4'($urandom_range(0, 15));
      cdb_valid     = ($urandom_range(0, 1) == 1);
      cdb_rob_id    = 4'($urandom_range(0, 3));
      cdb_value     = $urandom();
    end
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
